// File: rtl/tl_timed_cntr_if.sv
// rtl/tl_timed_cntr_if.sv - traffic-light controller signal bundle
// Ports:
//   tick     : one-clock time-base pulse, the only event that advances the timer
//   ta, tb   : street A / street B traffic sensors (1 = traffic present)
//   ped      : pedestrian request pulse
//   la, lb   : street A / B lights (00 green, 01 yellow, 10 red)
//   cnt      : remaining ticks in the current phase
//   ped_wait : latched pedestrian request still pending
interface tl_timed_cntr_if;
    logic       tick;
    logic       ta;
    logic       tb;
    logic       ped;
    logic [1:0] la;
    logic [1:0] lb;
    logic [3:0] cnt;
    logic       ped_wait;

    modport master (
        output tick, ta, tb, ped,
        input  la, lb, cnt, ped_wait
    );

    modport slave (
        input  tick, ta, tb, ped,
        output la, lb, cnt, ped_wait
    );
endinterface

// File: rtl/tl_timed_cntr.sv
// rtl/tl_timed_cntr.sv - two-street traffic-light controller with tick-timed phases
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : tl_timed_cntr_if.slave (tick/ta/tb/ped in, la/lb/cnt/ped_wait out)
// Parameters:
//   GREEN_T  : green phase length in ticks (1..16)
//   YELLOW_T : yellow phase length in ticks (1..16)
module tl_timed_cntr #(
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    tl_timed_cntr_if.slave    bus
);

    localparam logic [3:0] G_LOAD = 4'(GREEN_T - 1);
    localparam logic [3:0] Y_LOAD = 4'(YELLOW_T - 1);

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    typedef enum logic [1:0] {
        S0 = 2'd0,  // A green,  B red
        S1 = 2'd1,  // A yellow, B red
        S2 = 2'd2,  // A red,    B green
        S3 = 2'd3   // A red,    B yellow
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_la;
    logic [1:0] r_lb;
    logic       r_ped_wait;

    logic       w_expired;
    logic       w_enter_yellow;

    // A green phase may only end once its count has run out and either the
    // street has gone quiet or a pedestrian is waiting. Sensors only matter here.
    assign w_expired      = bus.tick && (r_cnt == 4'd0);
    assign w_enter_yellow = w_expired &&
                            (((r_state == S0) && (!bus.ta || r_ped_wait)) ||
                             ((r_state == S2) && (!bus.tb || r_ped_wait)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S0;
            r_cnt      <= G_LOAD;
            r_la       <= L_GREEN;
            r_lb       <= L_RED;
            r_ped_wait <= 1'b0;
        end else begin
            // A new request on the clearing edge wins over the clear.
            r_ped_wait <= bus.ped | (r_ped_wait & ~w_enter_yellow);

            if (bus.tick) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    // Lights change together with the state so they stay a
                    // pure function of the state register.
                    case (r_state)
                        S0: if (w_enter_yellow) begin
                            r_state <= S1;
                            r_cnt   <= Y_LOAD;
                            r_la    <= L_YELLOW;
                            r_lb    <= L_RED;
                        end
                        S1: begin
                            r_state <= S2;
                            r_cnt   <= G_LOAD;
                            r_la    <= L_RED;
                            r_lb    <= L_GREEN;
                        end
                        S2: if (w_enter_yellow) begin
                            r_state <= S3;
                            r_cnt   <= Y_LOAD;
                            r_la    <= L_RED;
                            r_lb    <= L_YELLOW;
                        end
                        S3: begin
                            r_state <= S0;
                            r_cnt   <= G_LOAD;
                            r_la    <= L_GREEN;
                            r_lb    <= L_RED;
                        end
                        default: begin
                            r_state <= S0;
                            r_cnt   <= G_LOAD;
                            r_la    <= L_GREEN;
                            r_lb    <= L_RED;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.la       = r_la;
    assign bus.lb       = r_lb;
    assign bus.cnt      = r_cnt;
    assign bus.ped_wait = r_ped_wait;

endmodule

// File: tb/tb_tl_timed_cntr.sv
// tb/tb_tl_timed_cntr.sv - self-checking bench for tl_timed_cntr
module tb_tl_timed_cntr;

    localparam int GREEN_T  = 5;
    localparam int YELLOW_T = 2;

    logic clk;
    logic rst_n;

    tl_timed_cntr_if bus ();

    tl_timed_cntr #(
        .GREEN_T  (GREEN_T),
        .YELLOW_T (YELLOW_T)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: phase index walks 0..3 around a ring, each phase has a
    // nominal duration, green phases can be extended by traffic.
    int phase_dur [4] = '{GREEN_T, YELLOW_T, GREEN_T, YELLOW_T};
    int light_a   [4] = '{0, 1, 2, 2};
    int light_b   [4] = '{2, 2, 0, 1};
    int m_phase;
    int m_rem;
    int m_pw;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_rem   = GREEN_T - 1;
        m_pw    = 0;
    endtask

    task automatic model_edge();
        int  clr;
        int  sensor;
        clr = 0;
        if (bus.tick) begin
            if (m_rem > 0) begin
                m_rem--;
            end else begin
                sensor = (m_phase == 0) ? int'(bus.ta) : int'(bus.tb);
                if ((m_phase % 2 == 1) || sensor == 0 || m_pw == 1) begin
                    m_phase = (m_phase + 1) % 4;
                    m_rem   = phase_dur[m_phase] - 1;
                    if (m_phase % 2 == 1) clr = 1;
                end
            end
        end
        if (bus.ped) m_pw = 1;
        else if (clr == 1) m_pw = 0;
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("la",       int'(bus.la),       light_a[m_phase]);
            chk("lb",       int'(bus.lb),       light_b[m_phase]);
            chk("cnt",      int'(bus.cnt),      m_rem);
            chk("ped_wait", int'(bus.ped_wait), m_pw);
        end
    end

    // One clock: drive inputs just after a falling edge, advance the model on
    // the rising edge, return at the next falling edge.
    task automatic step(input bit t, input bit a, input bit b, input bit p);
        bus.tick = t;
        bus.ta   = a;
        bus.tb   = b;
        bus.ped  = p;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input bit a, input bit b);
        for (int i = 0; i < n; i++) step(1'b1, a, b, 1'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input bit lit);
        bus.tick = 1'b0;
        bus.ped  = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (lit) begin
            chk("rst_la",  int'(bus.la),       0);
            chk("rst_lb",  int'(bus.lb),       2);
            chk("rst_cnt", int'(bus.cnt),      4);
            chk("rst_pw",  int'(bus.ped_wait), 0);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.tick = 1'b0;
        bus.ta   = 1'b0;
        bus.tb   = 1'b0;
        bus.ped  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        async_reset(1'b1);
        cmp_en = 1'b1;

        // Unconditional cycle timing.
        ticks(4, 1'b0, 1'b0);
        chk("r29_cnt", int'(bus.cnt), 0);
        chk("r29_la",  int'(bus.la),  0);
        ticks(1, 1'b0, 1'b0);
        chk("r29_la5",  int'(bus.la),  1);
        chk("r29_cnt5", int'(bus.cnt), 1);
        ticks(9, 1'b0, 1'b0);
        chk("r30_la",  int'(bus.la),  0);
        chk("r30_lb",  int'(bus.lb),  2);
        chk("r30_cnt", int'(bus.cnt), 4);

        // Traffic on A holds green at zero.
        async_reset(1'b0);
        ticks(20, 1'b1, 1'b0);
        chk("r31_la",  int'(bus.la),  0);
        chk("r31_cnt", int'(bus.cnt), 0);
        ticks(1, 1'b0, 1'b0);
        chk("r31_la2",  int'(bus.la),  1);
        chk("r31_cnt2", int'(bus.cnt), 1);

        // Pedestrian overrides traffic on A.
        async_reset(1'b0);
        ticks(1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("r32_pw", int'(bus.ped_wait), 1);
        ticks(3, 1'b1, 1'b0);
        chk("r32_la", int'(bus.la),       1);
        chk("r32_pw2", int'(bus.ped_wait), 0);

        // Request on the transition edge survives.
        async_reset(1'b0);
        ticks(4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("r33_la", int'(bus.la),       1);
        chk("r33_pw", int'(bus.ped_wait), 1);

        // Reset mid-S2, then idle with no ticks.
        async_reset(1'b0);
        ticks(9, 1'b0, 1'b0);
        chk("r34_la",  int'(bus.la),  2);
        chk("r34_lb",  int'(bus.lb),  0);
        chk("r34_cnt", int'(bus.cnt), 2);
        async_reset(1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, i[0], i[1], 1'b0);
        chk("r34_idle_cnt", int'(bus.cnt), 4);
        chk("r34_idle_la",  int'(bus.la),  0);

        // Randomized traffic, pedestrians, tick spacing and resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset(1'b0);
            end else begin
                step(($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 19) == 0));
            end
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_timed_cntr.md
TL_TIMED_CNTR -- requirements
Module: tl_timed_cntr

Interface
REQ-001 Parameter GREEN_T, default 5: green phase length in Tick pulses; legal range 1..16.
REQ-002 Parameter YELLOW_T, default 2: yellow phase length in Tick pulses; legal range 1..16.
REQ-003 CLK  input  1  single clock; all state changes occur on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Tick  input  1  one-CLK-wide time-base pulse; the only event that advances the timer or the phase.
REQ-006 Ta  input  1  street A traffic sensor; 1 means traffic present.
REQ-007 Tb  input  1  street B traffic sensor; 1 means traffic present.
REQ-008 Ped  input  1  pedestrian request pulse; sampled every CLK.
REQ-009 La  output  2  street A light: 00 green, 01 yellow, 10 red; 11 never driven.
REQ-010 Lb  output  2  street B light, same encoding as La.
REQ-011 Cnt  output  4  remaining Tick count in the current phase, for 7-segment display.
REQ-012 PedWait  output  1  latched pedestrian request that is still pending.

Function
REQ-013 The block SHALL implement four states: S0 (A green, B red), S1 (A yellow, B red), S2 (A red, B green), S3 (A red, B yellow).
REQ-014 La, Lb and PedWait SHALL be registered; La and Lb SHALL be decoded from the state register only.
REQ-015 On entry to a green state, Cnt SHALL load GREEN_T-1. On entry to a yellow state, Cnt SHALL load YELLOW_T-1.
REQ-016 When Tick=1 and Cnt>0, Cnt SHALL decrement by 1 and the state SHALL hold.
REQ-017 S0->S1 SHALL occur on a Tick with Cnt=0 and (Ta=0 or PedWait=1); otherwise S0 SHALL hold with Cnt held at 0.
REQ-018 S1->S2 SHALL occur on a Tick with Cnt=0.
REQ-019 S2->S3 SHALL occur on a Tick with Cnt=0 and (Tb=0 or PedWait=1); otherwise S2 SHALL hold with Cnt held at 0.
REQ-020 S3->S0 SHALL occur on a Tick with Cnt=0.
REQ-021 Every phase SHALL last at least its parameter length in Ticks; an unconditional green-yellow cycle SHALL last exactly 2*(GREEN_T+YELLOW_T) Ticks.
REQ-022 When Tick=0, state and Cnt SHALL hold regardless of Ta, Tb and Ped.
REQ-023 Ped=1 SHALL set PedWait on the next edge, in any state, with or without Tick.
REQ-024 PedWait SHALL clear on the edge that enters S1 or S3; if Ped=1 on that same edge, set SHALL win and PedWait SHALL remain 1.
REQ-025 Ta and Tb SHALL be sampled only on the transition-deciding Tick; changes between Ticks SHALL have no effect.
REQ-026 Cnt SHALL never underflow or wrap; the minimum value is 0.

Reset
REQ-027 While Reset=0, the block SHALL immediately, without CLK, force state S0, La=00, Lb=10, Cnt=GREEN_T-1 and PedWait=0.
REQ-028 Reset asserted in any state or mid-count SHALL discard the phase and pending request; the first Tick after release SHALL count from GREEN_T-1.

Verification (GREEN_T=5, YELLOW_T=2)
REQ-029 Reset pulse, then Ta=0 Tb=0 -> La=00 Lb=10 Cnt=4; after 4 Ticks Cnt=0 La=00; 5th Tick -> La=01 Cnt=1.
REQ-030 Ta=0 Tb=0, 14 Ticks from reset -> sequence S0(5) S1(2) S2(5) S3(2), then back to La=00 Cnt=4.
REQ-031 Ta=1 held for 20 Ticks -> La=00 Cnt=0 throughout after Tick 4; drop Ta, next Tick -> La=01 Cnt=1.
REQ-032 Ta=1, Ped pulse at Tick 2 -> PedWait=1 on next edge; 5th Tick -> La=01, PedWait=0.
REQ-033 Ped=1 on the same edge as the S0->S1 transition -> La=01 and PedWait=1 after that edge.
REQ-034 Reset driven low asynchronously mid-S2 (Cnt=2) between CLK edges -> outputs return to La=00 Lb=10 Cnt=4 PedWait=0 before the next edge; Tick=0 held 50 CLK -> no output change.
